// File: rtl/cascade_arbiter_sync.sv
// -----------------------------------------------------------------------------
// cascade_arbiter_sync
//   Synchronous N-way four-phase request arbiter. Merges N requesters into a
//   single four-phase request toward one downstream consumer and publishes the
//   winner as both an index and a one-hot select. MODE picks fixed priority
//   (lowest index wins) or round-robin (first request at/after a rotating
//   pointer). The winner is acknowledged only after downstream has accepted,
//   and arbitration reopens only once both winner and downstream released.
//
// Ports
//   clk_i         rising-edge clock
//   rst_i         synchronous, active-high reset
//   req_in_i      [N]    per-requester level request
//   ack_in_o      [N]    per-requester acknowledge (at most one bit high)
//   req_out_o            merged request to downstream
//   ack_out_i            downstream acknowledge
//   sel_idx_o     [IDXW] index of current winner (held until the next grant)
//   sel_onehot_o  [N]    one-hot winner select, zero while idle
//   proto_err_o          sticky: a winner dropped its request before its ack
//
// All outputs come straight from flops; nothing combinational reaches them
// from an input.
// -----------------------------------------------------------------------------

// Per-requester output cell: registers that lane's select and acknowledge bits.
module cascade_arbiter_sync_lane (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sel_d_i,
    input  logic ack_d_i,
    output logic sel_o,
    output logic ack_o
);
    logic sel_q;
    logic ack_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q <= 1'b0;
            ack_q <= 1'b0;
        end else begin
            sel_q <= sel_d_i;
            ack_q <= ack_d_i;
        end
    end

    assign sel_o = sel_q;
    assign ack_o = ack_q;
endmodule

module cascade_arbiter_sync #(
    parameter int N    = 32,
    parameter int MODE = 0,
    parameter int IDXW = $clog2(N)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    req_in_i,
    output logic [N-1:0]    ack_in_o,
    output logic            req_out_o,
    input  logic            ack_out_i,
    output logic [IDXW-1:0] sel_idx_o,
    output logic [N-1:0]    sel_onehot_o,
    output logic            proto_err_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IDXW-1:0] win_q, win_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic            perr_q, perr_d;
    // The current grant saw its winner drop early; ACK then only waits on
    // downstream so a requester that re-raises cannot wedge the handshake.
    logic            gerr_q, gerr_d;
    logic            req_out_q;
    logic [IDXW-1:0] sel_idx_q;

    logic [IDXW-1:0] pick_c;
    logic [IDXW-1:0] cand_c;
    logic            found_c;

    // Winner search. Fixed priority scans 0..N-1; round-robin scans starting
    // at ptr and wraps, so the first hit is the first request at/after ptr.
    always_comb begin
        pick_c  = '0;
        cand_c  = '0;
        found_c = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (MODE == 1) cand_c = IDXW'((int'(ptr_q) + i) % N);
            else           cand_c = IDXW'(i);
            if (!found_c && req_in_i[cand_c]) begin
                found_c = 1'b1;
                pick_c  = cand_c;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        perr_d  = perr_q;
        gerr_d  = gerr_q;
        unique case (state_q)
            IDLE: begin
                if (found_c) begin
                    win_d   = pick_c;
                    gerr_d  = 1'b0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req_in_i[win_q]) begin
                    perr_d = 1'b1;
                    gerr_d = 1'b1;
                end
                if (ack_out_i) state_d = ACK;
            end
            ACK: begin
                if (!ack_out_i && (gerr_q || !req_in_i[win_q])) begin
                    state_d = IDLE;
                    if (MODE == 1)
                        ptr_d = (win_q == IDXW'(N-1)) ? '0 : win_q + IDXW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            win_q     <= '0;
            ptr_q     <= '0;
            perr_q    <= 1'b0;
            gerr_q    <= 1'b0;
            req_out_q <= 1'b0;
            sel_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            ptr_q     <= ptr_d;
            perr_q    <= perr_d;
            gerr_q    <= gerr_d;
            // Outputs are decoded from next state so they appear on the same
            // edge the FSM moves, keeping the 1-cycle request latency.
            req_out_q <= (state_d == GRANT);
            sel_idx_q <= win_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        logic hit_d;
        assign hit_d = (win_d == IDXW'(g));
        cascade_arbiter_sync_lane u_lane (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .sel_d_i (hit_d && (state_d != IDLE)),
            .ack_d_i (hit_d && (state_d == ACK)),
            .sel_o   (sel_onehot_o[g]),
            .ack_o   (ack_in_o[g])
        );
    end

    assign req_out_o   = req_out_q;
    assign sel_idx_o   = sel_idx_q;
    assign proto_err_o = perr_q;
endmodule
